// File: rtl/mem_delay_responder.sv
// Test-bench memory responder: accepts read/write requests into a word memory and
// returns in-order responses through a small FIFO. Each side has its own pacing delay.
module mem_delay_responder #(
    parameter int unsigned p_opaq_bits       = 8,
    parameter int unsigned p_send_intv_delay = 1,
    parameter int unsigned p_recv_intv_delay = 1,
    parameter int unsigned p_num_words       = 256,
    parameter int unsigned p_buf_depth       = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,

    input  logic                   req_val,
    output logic                   req_rdy,
    input  logic [p_opaq_bits-1:0] req_opaque,
    input  logic                   req_type,
    input  logic [31:0]            req_addr,
    input  logic [31:0]            req_data,

    output logic                   resp_val,
    input  logic                   resp_rdy,
    output logic [p_opaq_bits-1:0] resp_opaque,
    output logic                   resp_type,
    output logic [31:0]            resp_addr,
    output logic [31:0]            resp_data
);

    localparam int unsigned AW = $clog2(p_num_words);
    localparam int unsigned PW = $clog2(p_buf_depth);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned DW = 4;

    localparam logic [DW-1:0] SEND_RELOAD = DW'(p_send_intv_delay - 1);
    localparam logic [DW-1:0] RECV_RELOAD = DW'(p_recv_intv_delay - 1);
    localparam logic [CW-1:0] FULL_COUNT  = CW'(p_buf_depth);

    typedef struct packed {
        logic [p_opaq_bits-1:0] opaque;
        logic                   typ;
        logic [31:0]            addr;
        logic [31:0]            data;
    } entry_t;

    logic [31:0]   mem    [p_num_words];
    entry_t        fifo_q [p_buf_depth];

    logic [PW-1:0] wr_ptr, rd_ptr, wr_ptr_next, rd_ptr_next;
    logic [CW-1:0] count, count_next;
    logic [DW-1:0] send_cnt, send_cnt_next, recv_cnt, recv_cnt_next;
    logic          req_rdy_next, resp_val_next;
    logic          push, pop;
    logic [AW-1:0] word_idx;
    entry_t        new_entry, head_q, head_next;
    logic          unused_addr_bits;

    assign push     = req_val && req_rdy;
    assign pop      = resp_val && resp_rdy;
    assign word_idx = req_addr[AW+1:2];
    assign unused_addr_bits = ^{req_addr[31:AW+2], req_addr[1:0]};

    // Response entry built from the request; reads see all earlier writes since writes land at acceptance
    always_comb begin
        new_entry        = '0;
        new_entry.opaque = req_opaque;
        new_entry.typ    = req_type;
        new_entry.addr   = req_addr;
        new_entry.data   = req_type ? 32'h0 : mem[word_idx];
    end

    // Next-state for FIFO pointers, occupancy, pacing counters and registered handshake flags
    always_comb begin
        wr_ptr_next   = wr_ptr;
        rd_ptr_next   = rd_ptr;
        count_next    = count;
        send_cnt_next = send_cnt;
        recv_cnt_next = recv_cnt;

        if (push) begin
            wr_ptr_next = wr_ptr + PW'(1);
        end
        if (pop) begin
            rd_ptr_next = rd_ptr + PW'(1);
        end
        count_next = count + CW'(push) - CW'(pop);

        if (push) begin
            send_cnt_next = SEND_RELOAD;
        end else if (send_cnt != '0) begin
            send_cnt_next = send_cnt - DW'(1);
        end

        if (pop) begin
            recv_cnt_next = RECV_RELOAD;
        end else if (recv_cnt != '0) begin
            recv_cnt_next = recv_cnt - DW'(1);
        end

        req_rdy_next  = (send_cnt_next == '0) && (count_next != FULL_COUNT);
        resp_val_next = (recv_cnt_next == '0) && (count_next != '0);

        // A push landing in the slot that becomes head must bypass the storage array
        if (push && (wr_ptr == rd_ptr_next)) begin
            head_next = new_entry;
        end else begin
            head_next = fifo_q[rd_ptr_next];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            send_cnt <= '0;
            recv_cnt <= '0;
            req_rdy  <= 1'b0;
            resp_val <= 1'b0;
        end else begin
            wr_ptr   <= wr_ptr_next;
            rd_ptr   <= rd_ptr_next;
            count    <= count_next;
            send_cnt <= send_cnt_next;
            recv_cnt <= recv_cnt_next;
            req_rdy  <= req_rdy_next;
            resp_val <= resp_val_next;
        end
    end

    // Storage and head payload carry no reset; stale contents are masked by resp_val
    always_ff @(posedge clk) begin
        if (push && req_type) begin
            mem[word_idx] <= req_data;
        end
        if (push) begin
            fifo_q[wr_ptr] <= new_entry;
        end
        head_q <= head_next;
    end

    assign resp_opaque = head_q.opaque;
    assign resp_type   = head_q.typ;
    assign resp_addr   = head_q.addr;
    assign resp_data   = head_q.data;

endmodule

// File: tb/tb_mem_delay_responder.sv
// Directed bench for mem_delay_responder: one instance with unit delays, one with
// send/recv delays of 3, sharing clock and reset.
module tb_mem_delay_responder;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        a_req_val, a_req_rdy, a_req_type, a_resp_val, a_resp_rdy, a_resp_type;
    logic [7:0]  a_req_opaque, a_resp_opaque;
    logic [31:0] a_req_addr, a_req_data, a_resp_addr, a_resp_data;

    logic        b_req_val, b_req_rdy, b_req_type, b_resp_val, b_resp_rdy, b_resp_type;
    logic [7:0]  b_req_opaque, b_resp_opaque;
    logic [31:0] b_req_addr, b_req_data, b_resp_addr, b_resp_data;

    int errors = 0;
    int checks = 0;

    mem_delay_responder #(
        .p_opaq_bits(8), .p_send_intv_delay(1), .p_recv_intv_delay(1),
        .p_num_words(256), .p_buf_depth(4)
    ) dut_a (
        .clk(clk), .rst_n(rst_n),
        .req_val(a_req_val), .req_rdy(a_req_rdy), .req_opaque(a_req_opaque),
        .req_type(a_req_type), .req_addr(a_req_addr), .req_data(a_req_data),
        .resp_val(a_resp_val), .resp_rdy(a_resp_rdy), .resp_opaque(a_resp_opaque),
        .resp_type(a_resp_type), .resp_addr(a_resp_addr), .resp_data(a_resp_data)
    );

    mem_delay_responder #(
        .p_opaq_bits(8), .p_send_intv_delay(3), .p_recv_intv_delay(3),
        .p_num_words(256), .p_buf_depth(4)
    ) dut_b (
        .clk(clk), .rst_n(rst_n),
        .req_val(b_req_val), .req_rdy(b_req_rdy), .req_opaque(b_req_opaque),
        .req_type(b_req_type), .req_addr(b_req_addr), .req_data(b_req_data),
        .resp_val(b_resp_val), .resp_rdy(b_resp_rdy), .resp_opaque(b_resp_opaque),
        .resp_type(b_resp_type), .resp_addr(b_resp_addr), .resp_data(b_resp_data)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic a_drive(input logic t, input logic [31:0] ad, input logic [31:0] dt,
                           input logic [7:0] op);
        a_req_val    = 1'b1;
        a_req_type   = t;
        a_req_addr   = ad;
        a_req_data   = dt;
        a_req_opaque = op;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int cyc;
        int acc [4];

        rst_n = 1'b0;
        a_req_val = 1'b0; a_req_type = 1'b0; a_req_addr = '0; a_req_data = '0; a_req_opaque = '0;
        a_resp_rdy = 1'b0;
        b_req_val = 1'b0; b_req_type = 1'b0; b_req_addr = '0; b_req_data = '0; b_req_opaque = '0;
        b_resp_rdy = 1'b0;
        acc = '{default: 0};

        // Reset values and first ready edge
        repeat (2) @(negedge clk);
        chk("rst_req_rdy",  64'(a_req_rdy),  64'(0));
        chk("rst_resp_val", 64'(a_resp_val), 64'(0));
        rst_n = 1'b1;
        #1;
        chk("pre_edge_rdy", 64'(a_req_rdy), 64'(0));
        @(negedge clk);
        chk("post_rst_rdy_a", 64'(a_req_rdy), 64'(1));
        chk("post_rst_rdy_b", 64'(b_req_rdy), 64'(1));

        // Write then read same word, back to back
        a_drive(1'b1, 32'h10, 32'hDEADBEEF, 8'd3);
        a_resp_rdy = 1'b1;
        @(negedge clk);
        chk("wr_resp_val",  64'(a_resp_val),    64'(1));
        chk("wr_resp_tag",  64'(a_resp_opaque), 64'(3));
        chk("wr_resp_type", 64'(a_resp_type),   64'(1));
        chk("wr_resp_addr", 64'(a_resp_addr),   64'h10);
        chk("wr_resp_data", 64'(a_resp_data),   64'(0));
        a_drive(1'b0, 32'h10, 32'h0, 8'd4);
        @(negedge clk);
        chk("rd_resp_val",  64'(a_resp_val),    64'(1));
        chk("rd_resp_tag",  64'(a_resp_opaque), 64'(4));
        chk("rd_resp_type", 64'(a_resp_type),   64'(0));
        chk("rd_resp_data", 64'(a_resp_data),   64'hDEADBEEF);
        chk("rd_req_rdy",   64'(a_req_rdy),     64'(1));
        a_req_val = 1'b0;
        @(negedge clk);
        chk("idle_resp_val", 64'(a_resp_val), 64'(0));

        // Fill the buffer with resp_rdy low, then a single pop
        a_resp_rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("fill_rdy", 64'(a_req_rdy), 64'(1));
            a_drive(1'b0, 32'h10, 32'h0, 8'(10 + i));
            @(negedge clk);
        end
        chk("full_rdy",      64'(a_req_rdy),     64'(0));
        chk("full_resp_val", 64'(a_resp_val),    64'(1));
        chk("full_head_tag", 64'(a_resp_opaque), 64'(10));
        a_drive(1'b0, 32'h10, 32'h0, 8'd14);
        a_resp_rdy = 1'b1;
        @(negedge clk);
        a_resp_rdy = 1'b0;
        chk("space_after_pop", 64'(a_req_rdy),     64'(1));
        chk("head_after_pop",  64'(a_resp_opaque), 64'(11));
        @(negedge clk);
        chk("refull_rdy", 64'(a_req_rdy), 64'(0));
        a_req_val  = 1'b0;
        a_resp_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_val",  64'(a_resp_val),    64'(1));
            chk("drain_tag",  64'(a_resp_opaque), 64'(11 + i));
            chk("drain_data", 64'(a_resp_data),   64'hDEADBEEF);
            @(negedge clk);
        end
        chk("drained_val", 64'(a_resp_val), 64'(0));

        // Address wrap modulo p_num_words*4
        a_drive(1'b1, 32'h400, 32'h55, 8'd20);
        @(negedge clk);
        chk("wrap_wr_tag", 64'(a_resp_opaque), 64'(20));
        a_drive(1'b0, 32'h0, 32'h0, 8'd21);
        @(negedge clk);
        chk("wrap_rd_tag",  64'(a_resp_opaque), 64'(21));
        chk("wrap_rd_addr", 64'(a_resp_addr),   64'(0));
        chk("wrap_rd_data", 64'(a_resp_data),   64'h55);
        a_req_val = 1'b0;
        @(negedge clk);

        // Reset with two responses pending
        a_resp_rdy = 1'b0;
        a_drive(1'b1, 32'h20, 32'hA5A5, 8'd30);
        @(negedge clk);
        a_drive(1'b0, 32'h20, 32'h0, 8'd31);
        @(negedge clk);
        a_req_val = 1'b0;
        chk("pend_val", 64'(a_resp_val),    64'(1));
        chk("pend_tag", 64'(a_resp_opaque), 64'(30));
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_val", 64'(a_resp_val), 64'(0));
        chk("async_rst_rdy", 64'(a_req_rdy),  64'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        a_resp_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("no_stale_val", 64'(a_resp_val), 64'(0));
        end
        a_drive(1'b0, 32'h20, 32'h0, 8'd32);
        @(negedge clk);
        a_req_val = 1'b0;
        chk("kept_tag",  64'(a_resp_opaque), 64'(32));
        chk("kept_data", 64'(a_resp_data),   64'hA5A5);
        a_drive(1'b0, 32'h10, 32'h0, 8'd33);
        @(negedge clk);
        a_req_val = 1'b0;
        chk("kept_data2", 64'(a_resp_data), 64'hDEADBEEF);

        // Send pacing of 3 with req_val held high
        b_req_type   = 1'b0;
        b_req_addr   = 32'h8;
        b_req_opaque = 8'd40;
        b_req_val    = 1'b1;
        n = 0;
        cyc = 0;
        while (n < 4 && cyc < 40) begin
            if (b_req_rdy) begin
                acc[n] = cyc;
                n++;
                @(posedge clk);
                #1;
                b_req_opaque = 8'(40 + n);
                if (n == 4) b_req_val = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        b_req_val = 1'b0;
        chk("send_accepts", 64'(n), 64'(4));
        for (int i = 0; i < 3; i++) chk("send_spacing", 64'(acc[i+1] - acc[i]), 64'(3));
        chk("send_full_rdy", 64'(b_req_rdy), 64'(0));

        // Recv pacing of 3 draining four buffered responses
        b_resp_rdy = 1'b1;
        n = 0;
        cyc = 0;
        while (n < 4 && cyc < 40) begin
            if (b_resp_val) begin
                chk("recv_tag",  64'(b_resp_opaque), 64'(40 + n));
                chk("recv_type", 64'(b_resp_type),   64'(0));
                acc[n] = cyc;
                n++;
            end
            @(negedge clk);
            cyc++;
        end
        chk("recv_handshakes", 64'(n), 64'(4));
        for (int i = 0; i < 3; i++) chk("recv_spacing", 64'(acc[i+1] - acc[i]), 64'(3));
        chk("recv_empty_val", 64'(b_resp_val), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
